// File: rtl/segre_store_buffer_q_pkg.sv
// -----------------------------------------------------------------------------
// segre_store_buffer_q_pkg
// Shared types and constants for the MEM-stage store buffer.
//   memop_data_type_e : access size of a load/store (BYTE/HALF/WORD)
//   sb_fsm_state_e    : drain FSM states
//   sb_entry_t        : one buffered store {valid, word addr, lane data, mask}
//   expand_mask()     : byte-enable mask -> 32-bit lane mask
// -----------------------------------------------------------------------------
package segre_store_buffer_q_pkg;

    localparam int unsigned ADDR_SIZE              = 32;
    localparam int unsigned WORD_SIZE              = 32;
    localparam int unsigned STORE_BUFFER_NUM_ELEMS = 4;
    localparam int unsigned SB_BYTE_LANES          = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_fsm_state_e;

    typedef struct packed {
        logic                     valid;
        logic [ADDR_SIZE-3:0]     waddr;  // word address, addr[1:0] dropped
        logic [WORD_SIZE-1:0]     data;   // bytes already in their lanes
        logic [SB_BYTE_LANES-1:0] mask;
    } sb_entry_t;

    function automatic logic [WORD_SIZE-1:0] expand_mask(input logic [SB_BYTE_LANES-1:0] m);
        logic [WORD_SIZE-1:0] lanes;
        for (int b = 0; b < SB_BYTE_LANES; b++) begin
            lanes[b*8 +: 8] = {8{m[b]}};
        end
        return lanes;
    endfunction

endpackage

// File: rtl/segre_store_buffer_q_byte_mask.sv
// -----------------------------------------------------------------------------
// segre_store_buffer_q_byte_mask
// Combinational decode of access size and low address bits into a byte-enable
// mask plus the right-aligned input data moved into its byte lanes.
//   memop_type   in  access size
//   addr_lo      in  addr[1:0]
//   data_in      in  right-aligned data
//   mask         out byte-enable mask
//   data_shifted out data_in truncated to the access size and lane-positioned
// -----------------------------------------------------------------------------
module segre_store_buffer_q_byte_mask
    import segre_store_buffer_q_pkg::*;
(
    input  memop_data_type_e         memop_type,
    input  logic [1:0]               addr_lo,
    input  logic [WORD_SIZE-1:0]     data_in,
    output logic [SB_BYTE_LANES-1:0] mask,
    output logic [WORD_SIZE-1:0]     data_shifted
);

    logic [WORD_SIZE-1:0] keep;

    always_comb begin
        mask = '0;
        keep = '0;
        case (memop_type)
            BYTE: begin
                mask = 4'b0001 << addr_lo;
                keep = 32'h0000_00FF;
            end
            HALF: begin
                mask = 4'b0011 << {addr_lo[1], 1'b0};
                keep = 32'h0000_FFFF;
            end
            WORD: begin
                mask = 4'hF;
                keep = 32'hFFFF_FFFF;
            end
            default: begin
                mask = '0;
                keep = '0;
            end
        endcase
        data_shifted = (data_in & keep) << {addr_lo, 3'b000};
    end

endmodule

// File: rtl/segre_store_buffer_q.sv
// -----------------------------------------------------------------------------
// segre_store_buffer_q
// N-entry circular store buffer between core and dcache. Stores retire into it
// in one cycle, loads get byte-granular forwarding from the youngest
// overlapping entry, and entries drain in order to the dcache either when the
// dcache is idle or through a full-drain FSM (fence/atomic).
//
// Optional feature: define SB_COALESCE_EN to merge a store into the youngest
// entry when the word addresses match (no new slot, accepted even when full).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_store_i             enqueue store (accepted only when !full_o)
//   req_load_i              load lookup this cycle
//   addr_i, data_i          byte address, right-aligned store data
//   memop_type_i            BYTE/HALF/WORD
//   flush_chance_i          dcache idle, head may be offered
//   flush_ack_i             dcache accepts head this cycle
//   drain_all_i             pulse: drain everything
//   full_o, empty_o         occupancy flags
//   hit_o, miss_o, trouble_o, data_load_o   load forwarding result
//   flush_valid_o, flush_addr_o, flush_data_o, flush_mask_o   head write to dcache
//   drained_o               1-cycle pulse when a drain request completes
// -----------------------------------------------------------------------------
module segre_store_buffer_q
    import segre_store_buffer_q_pkg::*;
#(
    parameter int unsigned NUM_ELEMS = STORE_BUFFER_NUM_ELEMS,
    parameter int unsigned ADDR_W    = ADDR_SIZE,
    parameter int unsigned DATA_W    = WORD_SIZE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_store_i,
    input  logic                     req_load_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        data_i,
    input  memop_data_type_e         memop_type_i,
    input  logic                     flush_chance_i,
    input  logic                     flush_ack_i,
    input  logic                     drain_all_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     hit_o,
    output logic                     miss_o,
    output logic                     trouble_o,
    output logic [DATA_W-1:0]        data_load_o,
    output logic                     flush_valid_o,
    output logic [ADDR_W-1:0]        flush_addr_o,
    output logic [DATA_W-1:0]        flush_data_o,
    output logic [SB_BYTE_LANES-1:0] flush_mask_o,
    output logic                     drained_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ELEMS);
    localparam int unsigned CNT_W = $clog2(NUM_ELEMS + 1);

    typedef logic [ADDR_SIZE-3:0] waddr_t;

    sb_entry_t        entries [NUM_ELEMS];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] young;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    sb_fsm_state_e    state;
    logic             drained;

    waddr_t                   req_waddr;
    logic [SB_BYTE_LANES-1:0] store_mask;
    logic [DATA_W-1:0]        store_data;
    logic [SB_BYTE_LANES-1:0] load_mask;
    logic [DATA_W-1:0]        load_lanes;

    logic             flush_valid;
    logic             pop;
    logic             push;
    logic             coalesce;
    logic             look_found;
    logic             look_covered;
    logic [IDX_W-1:0] look_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             misaligned;

    assign req_waddr = waddr_t'(addr_i[ADDR_W-1:2]);
    assign young     = tail - IDX_W'(1);

    // Store path: mask and lane-positioned write data.
    segre_store_buffer_q_byte_mask u_store_mask (
        .memop_type   (memop_type_i),
        .addr_lo      (addr_i[1:0]),
        .data_in      (data_i),
        .mask         (store_mask),
        .data_shifted (store_data)
    );

    // Load path: feeding all-ones yields the lane mask used to extract bytes.
    segre_store_buffer_q_byte_mask u_load_mask (
        .memop_type   (memop_type_i),
        .addr_lo      (addr_i[1:0]),
        .data_in      ({DATA_W{1'b1}}),
        .mask         (load_mask),
        .data_shifted (load_lanes)
    );

    // Occupancy flags come from registered state only, so a pop in the same
    // cycle never lets a store into a full buffer.
    assign full_o  = (count == CNT_W'(NUM_ELEMS));
    assign empty_o = (count == '0);

    assign flush_valid = !empty_o && (flush_chance_i || (state == SB_DRAIN));
    assign pop         = flush_valid && flush_ack_i;

`ifdef SB_COALESCE_EN
    // Merge into the youngest entry unless it is the head leaving this cycle.
    assign coalesce = req_store_i && !empty_o && entries[young].valid &&
                      (entries[young].waddr == req_waddr) &&
                      !((young == head) && pop);
`else
    assign coalesce = 1'b0;
`endif

    assign push = req_store_i && !full_o && !coalesce;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Scan oldest to youngest; the last overlapping entry seen is the youngest.
    always_comb begin
        look_found = 1'b0;
        look_idx   = head;
        scan_idx   = head;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            scan_idx = head + IDX_W'(i);
            if ((CNT_W'(i) < count) && entries[scan_idx].valid &&
                (entries[scan_idx].waddr == req_waddr) &&
                ((entries[scan_idx].mask & load_mask) != '0)) begin
                look_found = 1'b1;
                look_idx   = scan_idx;
            end
        end
    end

    assign look_covered = ((entries[look_idx].mask & load_mask) == load_mask);

    assign hit_o     = req_load_i && look_found && look_covered;
    assign trouble_o = req_load_i && look_found && !look_covered;
    assign miss_o    = req_load_i && !look_found;

    assign data_load_o = hit_o ?
        ((entries[look_idx].data & load_lanes) >> {addr_i[1:0], 3'b000}) : '0;

    assign flush_valid_o = flush_valid;
    assign flush_addr_o  = empty_o ? '0 : {entries[head].waddr[ADDR_W-3:0], 2'b00};
    assign flush_data_o  = empty_o ? '0 : entries[head].data;
    assign flush_mask_o  = empty_o ? '0 : entries[head].mask;
    assign drained_o     = drained;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= SB_IDLE;
            drained <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (coalesce) begin
                entries[young].data <= (entries[young].data & ~expand_mask(store_mask)) |
                                       store_data;
                entries[young].mask <= entries[young].mask | store_mask;
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, waddr: req_waddr,
                                   data: store_data, mask: store_mask};
                tail <= tail + IDX_W'(1);
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= head + IDX_W'(1);
            end
            count <= count_next;

            drained <= 1'b0;
            case (state)
                SB_IDLE: begin
                    if (drain_all_i) begin
                        // Nothing left after this cycle: complete immediately.
                        if (count_next == '0) begin
                            state   <= SB_DONE;
                            drained <= 1'b1;
                        end else begin
                            state <= SB_DRAIN;
                        end
                    end
                end
                SB_DRAIN: begin
                    if (count_next == '0) begin
                        state   <= SB_DONE;
                        drained <= 1'b1;
                    end
                end
                SB_DONE: state <= SB_IDLE;
                default: state <= SB_IDLE;
            endcase
        end
    end

    assign misaligned = ((memop_type_i == HALF) && addr_i[0]) ||
                        ((memop_type_i == WORD) && (addr_i[1:0] != 2'b00));

    a_aligned_access: assert property (@(posedge clk_i) disable iff (rst_i)
        !((req_store_i || req_load_i) && misaligned))
        else $error("store buffer: misaligned HALF/WORD access");

endmodule
